// File: rtl/dzcpu_useq.sv
// Microcode sequencer for the dzcpu core: owns the uPC and the flow FSM, and decodes
// jumps, micro-calls/returns, memory waits and stalls into ROM address and commit enables.
module dzcpu_useq #(
    parameter int UPC_W       = 8,
    parameter int UOP_W       = 16,
    parameter int CSEL_W      = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   iClock,
    input  logic                   iReset_n,
    input  logic [UOP_W-1:0]       iUop,
    input  logic [UPC_W-1:0]       iDispatchIdx,
    input  logic [UPC_W-1:0]       iExtDispatchIdx,
    input  logic [(2**CSEL_W)-1:0] iCond,
    input  logic                   iMemReady,
    input  logic                   iStall,
    output logic [UPC_W-1:0]       oUpc,
    output logic                   oUopValid,
    output logic                   oPcInc,
    output logic                   oFlowStart,
    output logic                   oFlowDone,
    output logic [1:0]             oError
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0] SEQ_NEXT         = 4'd0;
    localparam logic [3:0] SEQ_EOF          = 4'd1;
    localparam logic [3:0] SEQ_EOF_IF       = 4'd2;
    localparam logic [3:0] SEQ_EOF_IFN      = 4'd3;
    localparam logic [3:0] SEQ_JMP          = 4'd4;
    localparam logic [3:0] SEQ_JMP_IF       = 4'd5;
    localparam logic [3:0] SEQ_CALL         = 4'd6;
    localparam logic [3:0] SEQ_RET          = 4'd7;
    localparam logic [3:0] SEQ_DISPATCH_EXT = 4'd8;
    localparam logic [3:0] SEQ_WAIT         = 4'd9;

    typedef enum logic [2:0] {
        ST_AFTER_RESET = 3'd0,
        ST_START_FLOW  = 3'd1,
        ST_RUN_FLOW    = 3'd2,
        ST_WAIT_MEM    = 3'd3,
        ST_END_FLOW    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [UPC_W-1:0] upc_r;
    logic [UPC_W-1:0] next_upc_s;
    logic [UPC_W-1:0] upc_inc_s;
    logic [SP_W-1:0]  sp_r;
    logic [SP_W-1:0]  next_sp_s;
    logic [UPC_W-1:0] stack_r [STACK_DEPTH];
    logic [1:0]       error_r;

    logic [3:0]        seq_s;
    logic              ipc_s;
    logic [CSEL_W-1:0] csel_s;
    logic [UPC_W-1:0]  tgt_s;
    logic              cond_s;
    logic              sp_full_s;
    logic              sp_empty_s;
    logic              push_s;
    logic              set_ovf_s;
    logic              set_unf_s;
    logic              uop_valid_s;
    logic              pc_inc_s;
    logic              flow_start_s;
    logic              flow_done_s;
    logic              unused_uop_s;

    assign seq_s      = iUop[UOP_W-1 -: 4];
    assign ipc_s      = iUop[UOP_W-5];
    assign csel_s     = iUop[UOP_W-6 -: CSEL_W];
    assign tgt_s      = iUop[UPC_W-1:0];
    assign cond_s     = iCond[csel_s];
    assign upc_inc_s  = upc_r + UPC_W'(1);
    assign sp_full_s  = (sp_r == SP_W'(STACK_DEPTH));
    assign sp_empty_s = (sp_r == '0);

    // Spare microinstruction bits between CSEL and TGT carry no sequencer meaning.
    assign unused_uop_s = ^iUop;

    // Next-state, uPC/SP update and commit-enable decode for the current microinstruction.
    always_comb begin
        next_state_s = state_r;
        next_upc_s   = upc_r;
        next_sp_s    = sp_r;
        push_s       = 1'b0;
        set_ovf_s    = 1'b0;
        set_unf_s    = 1'b0;
        uop_valid_s  = 1'b0;
        pc_inc_s     = 1'b0;
        flow_start_s = 1'b0;
        flow_done_s  = 1'b0;
        case (state_r)
            ST_AFTER_RESET: begin
                next_state_s = ST_START_FLOW;
            end
            ST_START_FLOW: begin
                flow_start_s = 1'b1;
                next_upc_s   = iDispatchIdx;
                next_sp_s    = '0;
                next_state_s = ST_RUN_FLOW;
            end
            ST_RUN_FLOW: begin
                if (iStall) begin
                    next_state_s = ST_RUN_FLOW;
                end else begin
                    uop_valid_s = 1'b1;
                    pc_inc_s    = ipc_s;
                    case (seq_s)
                        SEQ_NEXT: next_upc_s = upc_inc_s;
                        SEQ_EOF:  next_state_s = ST_END_FLOW;
                        SEQ_EOF_IF: begin
                            if (cond_s) next_state_s = ST_END_FLOW;
                            else        next_upc_s   = upc_inc_s;
                        end
                        SEQ_EOF_IFN: begin
                            if (!cond_s) next_state_s = ST_END_FLOW;
                            else         next_upc_s   = upc_inc_s;
                        end
                        SEQ_JMP: next_upc_s = tgt_s;
                        SEQ_JMP_IF: begin
                            if (cond_s) next_upc_s = tgt_s;
                            else        next_upc_s = upc_inc_s;
                        end
                        SEQ_CALL: begin
                            // A call into a full stack is flagged and falls through.
                            if (sp_full_s) begin
                                set_ovf_s  = 1'b1;
                                next_upc_s = upc_inc_s;
                            end else begin
                                push_s     = 1'b1;
                                next_sp_s  = sp_r + SP_W'(1);
                                next_upc_s = tgt_s;
                            end
                        end
                        SEQ_RET: begin
                            if (sp_empty_s) begin
                                set_unf_s    = 1'b1;
                                next_state_s = ST_END_FLOW;
                            end else begin
                                next_sp_s  = sp_r - SP_W'(1);
                                next_upc_s = stack_r[IDX_W'(sp_r - SP_W'(1))];
                            end
                        end
                        SEQ_DISPATCH_EXT: next_upc_s = iExtDispatchIdx;
                        SEQ_WAIT: begin
                            if (iMemReady) begin
                                next_upc_s = upc_inc_s;
                            end else begin
                                uop_valid_s  = 1'b0;
                                pc_inc_s     = 1'b0;
                                next_state_s = ST_WAIT_MEM;
                            end
                        end
                        default: next_upc_s = upc_inc_s;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (iMemReady && !iStall) begin
                    uop_valid_s  = 1'b1;
                    pc_inc_s     = ipc_s;
                    next_upc_s   = upc_inc_s;
                    next_state_s = ST_RUN_FLOW;
                end else begin
                    next_state_s = ST_WAIT_MEM;
                end
            end
            ST_END_FLOW: begin
                flow_done_s  = 1'b1;
                next_state_s = ST_START_FLOW;
            end
            default: begin
                next_state_s = ST_AFTER_RESET;
            end
        endcase
    end

    // Flow FSM, uPC, stack pointer and sticky error flags.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_r <= ST_AFTER_RESET;
            upc_r   <= '0;
            sp_r    <= '0;
            error_r <= 2'b00;
        end else begin
            state_r <= next_state_s;
            upc_r   <= next_upc_s;
            sp_r    <= next_sp_s;
            error_r <= error_r | {set_unf_s, set_ovf_s};
        end
    end

    // Return-address storage; contents survive flow boundaries, only SP is rewound.
    always_ff @(posedge iClock) begin
        if (push_s) begin
            stack_r[IDX_W'(sp_r)] <= upc_inc_s;
        end
    end

    assign oUpc       = upc_r;
    assign oUopValid  = uop_valid_s;
    assign oPcInc     = pc_inc_s;
    assign oFlowStart = flow_start_s;
    assign oFlowDone  = flow_done_s;
    assign oError     = error_r;

endmodule
